// File: rtl/miriscv_lsu_pkg.sv
// Shared types for the memory arbiter: source IDs, arbiter FSM states, bus width.
package miriscv_lsu_pkg;

   localparam int XLEN          = 32;
   localparam int ARB_MAX_OUTST = 2;

   typedef enum logic {
      ARB_SRC_INSTR = 1'b0,
      ARB_SRC_DATA  = 1'b1
   } arb_src_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD_I = 2'd1,
      HOLD_D = 2'd2
   } arb_state_e;

endpackage

// File: rtl/miriscv_mem_arbiter_if.sv
// Instruction, data and memory-port signals of the arbiter; slave is the arbiter's view,
// master is the view of the requesters and memory around it.
interface miriscv_mem_arbiter_if;
   import miriscv_lsu_pkg::*;

   logic            instr_req_i;
   logic [XLEN-1:0] instr_addr_i;
   logic            instr_gnt_o;
   logic            instr_rvalid_o;
   logic [XLEN-1:0] instr_rdata_o;

   logic            data_req_i;
   logic            data_we_i;
   logic [3:0]      data_be_i;
   logic [XLEN-1:0] data_addr_i;
   logic [XLEN-1:0] data_wdata_i;
   logic            data_gnt_o;
   logic            data_rvalid_o;
   logic [XLEN-1:0] data_rdata_o;

   logic            mem_req_o;
   logic            mem_we_o;
   logic [3:0]      mem_be_o;
   logic [XLEN-1:0] mem_addr_o;
   logic [XLEN-1:0] mem_wdata_o;
   logic            mem_gnt_i;
   logic            mem_rvalid_i;
   logic [XLEN-1:0] mem_rdata_i;

   logic            arb_err_o;
   logic            arb_busy_o;

   modport slave (
      input  instr_req_i, instr_addr_i,
      output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
      input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      output data_gnt_o, data_rvalid_o, data_rdata_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      output arb_err_o, arb_busy_o
   );

   modport master (
      output instr_req_i, instr_addr_i,
      input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
      output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      input  data_gnt_o, data_rvalid_o, data_rdata_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      input  arb_err_o, arb_busy_o
   );

endinterface

// File: rtl/miriscv_arb_id_fifo.sv
// In-order FIFO of source IDs for in-flight transactions; dout is the oldest entry.
// Pointers wrap at DEPTH; a pop on empty or a push on full without a pop is ignored.
module miriscv_arb_id_fifo
   import miriscv_lsu_pkg::*;
#(
   parameter  int DEPTH = ARB_MAX_OUTST,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push,
   input  arb_src_e      din,
   input  logic          pop,
   output arb_src_e      dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   arb_src_e        mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem_q[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr] <= din;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Instr/data arbiter onto one memory port: round-robin on contention, zero-cycle grant, in-order rvalid routing.
// Selection is frozen until the pending grant; new requests stall while MAX_OUTST transactions are in flight.
module miriscv_mem_arbiter
   import miriscv_lsu_pkg::*;
#(
   parameter int MAX_OUTST = ARB_MAX_OUTST
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   miriscv_mem_arbiter_if.slave  bus
);
   localparam int CW = $clog2(MAX_OUTST + 1);

   arb_state_e    state_q, state_d;
   arb_src_e      prio_q;
   arb_src_e      sel;
   arb_src_e      fifo_dout;
   logic [CW-1:0] fifo_count;
   logic          fifo_full, fifo_empty;
   logic          sel_req, mem_req, accept, contested, rsp_ok, err_q;

   always_comb begin
      sel     = prio_q;
      state_d = IDLE;
      case (state_q)
         HOLD_I:  sel = ARB_SRC_INSTR;
         HOLD_D:  sel = ARB_SRC_DATA;
         default: if (bus.instr_req_i ^ bus.data_req_i)
                     sel = bus.data_req_i ? ARB_SRC_DATA : ARB_SRC_INSTR;
      endcase
      sel_req = (sel == ARB_SRC_DATA) ? bus.data_req_i : bus.instr_req_i;
      // A full FIFO is checked before the same-cycle pop, so a pop never frees a slot early.
      mem_req = sel_req & ~fifo_full & ~rst_i;
      if (mem_req & ~bus.mem_gnt_i)
         state_d = (sel == ARB_SRC_DATA) ? HOLD_D : HOLD_I;
   end

   assign accept    = mem_req & bus.mem_gnt_i;
   assign contested = bus.instr_req_i & bus.data_req_i;
   assign rsp_ok    = bus.mem_rvalid_i & ~fifo_empty & ~rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         prio_q  <= ARB_SRC_DATA;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept & contested)
            prio_q <= (sel == ARB_SRC_DATA) ? ARB_SRC_INSTR : ARB_SRC_DATA;
         if (bus.mem_rvalid_i & fifo_empty)
            err_q <= 1'b1;
      end
   end

   miriscv_arb_id_fifo #(.DEPTH(MAX_OUTST)) u_id_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (accept),
      .din   (sel),
      .pop   (bus.mem_rvalid_i),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.mem_req_o      = mem_req;
   assign bus.mem_we_o       = (sel == ARB_SRC_DATA) & bus.data_we_i;
   assign bus.mem_be_o       = (sel == ARB_SRC_DATA) ? bus.data_be_i : 4'hF;
   assign bus.mem_addr_o     = (sel == ARB_SRC_DATA) ? bus.data_addr_i : bus.instr_addr_i;
   assign bus.mem_wdata_o    = bus.data_wdata_i;

   assign bus.instr_gnt_o    = accept & (sel == ARB_SRC_INSTR);
   assign bus.data_gnt_o     = accept & (sel == ARB_SRC_DATA);
   assign bus.instr_rvalid_o = rsp_ok & (fifo_dout == ARB_SRC_INSTR);
   assign bus.data_rvalid_o  = rsp_ok & (fifo_dout == ARB_SRC_DATA);
   assign bus.instr_rdata_o  = bus.mem_rdata_i;
   assign bus.data_rdata_o   = bus.mem_rdata_i;

   assign bus.arb_err_o      = err_q & ~rst_i;
   assign bus.arb_busy_o     = (fifo_count != '0) & ~rst_i;

endmodule

// File: doc/miriscv_mem_arbiter.md
MIRISCV_MEM_ARBITER -- requirements
Module: miriscv_mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 2: maximum in-flight memory transactions, legal range 1..4.
REQ-002 SHALL have these ports:
- clk_i  in  1: clock.
- rst_i  in  1: reset; synchronous and active-high.
REQ-003 SHALL have instruction-side ports (read-only):
- instr_req_i  in  1: request.
- instr_addr_i  in  XLEN: byte address.
- instr_gnt_o  out  1: grant.
- instr_rvalid_o  out  1: response valid.
- instr_rdata_o  out  XLEN: read data.
REQ-004 SHALL have data-side ports:
- data_req_i  in  1: request.
- data_we_i  in  1: write enable.
- data_be_i  in  4: byte enables.
- data_addr_i  in  XLEN: byte address.
- data_wdata_i  in  XLEN: write data.
- data_gnt_o  out  1: grant.
- data_rvalid_o  out  1: response valid.
- data_rdata_o  out  XLEN: read data.
REQ-005 SHALL have shared memory-port ports:
- mem_req_o  out  1: request.
- mem_we_o  out  1: write enable.
- mem_be_o  out  4: byte enables.
- mem_addr_o  out  XLEN: byte address.
- mem_wdata_o  out  XLEN: write data.
- mem_gnt_i  in  1: grant.
- mem_rvalid_i  in  1: response valid.
- mem_rdata_i  in  XLEN: read data.
REQ-006 SHALL have status ports:
- arb_err_o  out  1: sticky protocol error.
- arb_busy_o  out  1: outstanding count nonzero.

Function
REQ-007 SHALL use the handshake: a request is accepted in the cycle req & gnt are both high; the requester holds req and its fields stable until gnt.
REQ-008 SHALL use an FSM with states IDLE, HOLD_I and HOLD_D; HOLD_x is entered when mem_req_o is high for source x and mem_gnt_i is low.
REQ-009 SHALL keep the selection fixed in HOLD_x until mem_gnt_i; the arbiter never switches sources mid-handshake.
REQ-010 SHALL select in IDLE as follows:
- Only one requester active: that requester is selected.
- Both active: the requester other than the last contested winner is selected (round-robin).
- The round-robin pointer resets to favour data.
REQ-011 SHALL update the round-robin pointer only on an accepted transaction made while both requests were high.
REQ-012 SHALL drive mem_req_o = selected req & ~fifo_full; the mem_* fields mux combinationally from the selected source.
REQ-013 SHALL force mem_we_o=0 and mem_be_o=4'hF when instruction is selected.
REQ-014 SHALL give grant with zero-cycle latency: x_gnt_o = mem_gnt_i & mem_req_o & (sel==x), and the unselected gnt is 0.
REQ-015 SHALL push the source ID (1 bit) into an in-order ID FIFO of depth MAX_OUTST on each accepted transaction; writes are included.
REQ-016 SHALL, on mem_rvalid_i with the FIFO non-empty, pop the FIFO and assert x_rvalid_o for the popped source in the same cycle.
REQ-017 SHALL route mem_rdata_i to both rdata outputs unconditionally.
REQ-018 SHALL, on a simultaneous accept and rvalid, both push and pop; the count is unchanged, including when the FIFO is full.
REQ-019 SHALL block new grants when the FIFO is full (count==MAX_OUTST), except a same-cycle pop does not unblock.
REQ-020 SHALL, on mem_rvalid_i with the FIFO empty:
- Set arb_err_o, which stays set until reset.
- Assert no rvalid output.
- Leave the FIFO unchanged.
REQ-021 SHALL wrap the FIFO pointers modulo MAX_OUTST; the count width is $clog2(MAX_OUTST+1).

Reset
REQ-022 SHALL, while rst_i is high:
- Drive mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, arb_err_o and arb_busy_o to 0.
- Put the FSM in IDLE, clear the FIFO pointers and count, and set the round-robin pointer to data.
REQ-023 SHALL drop all outstanding IDs on reset mid-operation; responses arriving after reset take the REQ-020 path.

Structure
REQ-024 SHALL place the source ID encoding (ARB_SRC_INSTR=0, ARB_SRC_DATA=1), the FSM state typedef and the MAX_OUTST default in miriscv_lsu_pkg.
REQ-025 SHALL implement the ID FIFO as one sub-module, miriscv_arb_id_fifo, with push, pop, full, empty, count and dout ports.

Verification
REQ-026 Single data read: data_req=1, addr=0x100, gnt next cycle, rvalid 2 cycles later -> data_gnt_o is 1 for one cycle, and data_rvalid_o=1 with data_rdata_o=mem_rdata_i.
REQ-027 Contention: both requesters held high for 4 accepts with gnt=1 every cycle -> accept order is D, I, D, I.
REQ-028 Hold: data wins, gnt held low for 3 cycles while instr_req rises -> mem_addr_o stays at the data address until gnt.
REQ-029 Full: MAX_OUTST=2, 2 accepts with no rvalid -> mem_req_o=0; next rvalid pops; the following cycle mem_req_o=1.
REQ-030 Interleaved: I then D accepted, rvalid pulses in 2 cycles -> instr_rvalid_o, then data_rvalid_o; a simultaneous accept+rvalid keeps count=1.
REQ-031 Spurious: rvalid with count=0 -> arb_err_o=1 and stays 1; rst_i clears it and all outputs are 0 the next cycle.
